// File: rtl/trunk_access_sequencer_pkg.sv
// trunk_access_sequencer_pkg: state encodings, select modes and line counts shared by the sequencer and its bench
package trunk_access_sequencer_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACTIVE = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;
    localparam logic MODE_WORD  = 1'b1;
    localparam logic MODE_LANE  = 1'b0;
    localparam int   LINES_WORD = 32;
    localparam int   LINES_LANE = 8;
endpackage

// File: rtl/trunk_access_sequencer.sv
// trunk_access_sequencer: accepts one burst (req_valid/req_ready, req_mode, req_start, req_len, abort) and strobes trunk_enable over consecutive trunk_sel lines, reporting busy/done; all outputs registered
module trunk_access_sequencer
    import trunk_access_sequencer_pkg::*;
#(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_mode,
    input  logic [4:0] req_start,
    input  logic [5:0] req_len,
    input  logic       abort,
    output logic [4:0] trunk_sel,
    output logic       trunk_byte_mode,
    output logic       trunk_enable,
    output logic       busy,
    output logic       done
);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);

    state_t     state, state_n;
    logic [4:0] sel_n;
    logic       mode_n;
    logic [5:0] rem, rem_n;
    logic [3:0] phase, phase_n;

    function automatic logic [4:0] next_sel(input logic [4:0] s, input logic m);
        return 5'((int'(s) + 1) % (m == MODE_WORD ? LINES_WORD : LINES_LANE));
    endfunction

    always_comb begin
        state_n = state;
        sel_n   = trunk_sel;
        mode_n  = trunk_byte_mode;
        rem_n   = rem;
        phase_n = phase;
        case (state)
            IDLE: if (req_valid) begin
                mode_n  = req_mode;
                sel_n   = req_mode == MODE_LANE ? {2'b00, req_start[2:0]} : req_start;
                rem_n   = req_len;
                state_n = req_len == 6'd0 ? DONE : SETUP;
            end
            SETUP: begin
                state_n = abort ? DONE : ACTIVE;
                phase_n = PULSE_LAST;
            end
            ACTIVE: if (abort) state_n = DONE;
            else if (phase != 4'd0) phase_n = phase - 4'd1;
            else if (rem > 6'd1) begin
                state_n = GAP;
                rem_n   = rem - 6'd1;
                sel_n   = next_sel(trunk_sel, trunk_byte_mode);
                phase_n = GAP_LAST;
            end
            else state_n = DONE;
            GAP: if (abort) state_n = DONE;
            else if (phase != 4'd0) phase_n = phase - 4'd1;
            else begin
                state_n = ACTIVE;
                phase_n = PULSE_LAST;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= IDLE;
            trunk_sel       <= 5'd0;
            trunk_byte_mode <= 1'b0;
            rem             <= 6'd0;
            phase           <= 4'd0;
            trunk_enable    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            req_ready       <= 1'b1;
        end else begin
            state           <= state_n;
            trunk_sel       <= sel_n;
            trunk_byte_mode <= mode_n;
            rem             <= rem_n;
            phase           <= phase_n;
            trunk_enable    <= state_n == ACTIVE;
            busy            <= state_n != IDLE;
            done            <= state_n == DONE;
            req_ready       <= state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_trunk_access_sequencer.sv
// tb_trunk_access_sequencer: directed and random bursts checked cycle by cycle against a timeline built from the burst rules
module tb_trunk_access_sequencer;
    localparam int P = 2;
    localparam int G = 1;

    typedef struct {
        int   sel;
        logic en;
        logic dn;
        logic chk_sel;
        logic idle;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_mode = 1'b0;
    logic [4:0] req_start = 5'd0;
    logic [5:0] req_len = 6'd0;
    logic       abort = 1'b0;
    logic [4:0] trunk_sel;
    logic       trunk_byte_mode;
    logic       trunk_enable;
    logic       busy;
    logic       done;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    trunk_access_sequencer #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_mode(req_mode),
        .req_start(req_start),
        .req_len(req_len),
        .abort(abort),
        .trunk_sel(trunk_sel),
        .trunk_byte_mode(trunk_byte_mode),
        .trunk_enable(trunk_enable),
        .busy(busy),
        .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input int sel, input logic en, input logic dn, input logic cs, input logic idle);
        cyc_t c;
        c.sel = sel;
        c.en = en;
        c.dn = dn;
        c.chk_sel = cs;
        c.idle = idle;
        return c;
    endfunction

    // ev: 0 none, 1 abort held during cycle 'at', 2 reset asserted during cycle 'at', 3 abort during the accept cycle
    task automatic burst(input logic m, input int st, input int len, input int ev, input int at);
        cyc_t q[$];
        int lines = m ? 32 : 8;
        int s0 = m ? st : st % 8;
        int full;
        int last;
        logic [4:0] prev;
        q.push_back(mk(0, 0, 0, 0, 1));
        if (len == 0) q.push_back(mk(0, 0, 1, 0, 0));
        else begin
            q.push_back(mk(s0, 0, 0, 1, 0));
            for (int i = 0; i < len; i++) begin
                repeat (P) q.push_back(mk((s0 + i) % lines, 1, 0, 1, 0));
                if (i < len - 1) repeat (G) q.push_back(mk((s0 + i + 1) % lines, 0, 0, 1, 0));
            end
            q.push_back(mk(0, 0, 1, 0, 0));
        end
        full = q.size() - 1;
        if ((ev == 1 || ev == 2) && at >= 1 && at < full) begin
            while (q.size() > at + 1) void'(q.pop_back());
            q.push_back(ev == 1 ? mk(0, 0, 1, 0, 0) : mk(0, 0, 0, 1, 1));
        end
        last = q.size() - 1;
        req_valid = 1'b1;
        req_mode = m;
        req_start = 5'(st);
        req_len = 6'(len);
        if (ev == 3) abort = 1'b1;
        prev = trunk_sel;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                req_mode = 1'($urandom);
                req_start = 5'($urandom);
                req_len = 6'($urandom_range(0, 32));
                if (ev == 3) abort = 1'b0;
            end
            if (q[k].chk_sel) check("sel", trunk_sel, q[k].sel);
            check("en", trunk_enable, q[k].en);
            check("done", done, q[k].dn);
            check("busy", busy, !q[k].idle);
            check("ready", req_ready, q[k].idle);
            if (trunk_sel !== prev) check("glitch_en", trunk_enable, 0);
            prev = trunk_sel;
            if (ev == 1 && k == at) abort = 1'b1;
            if (ev == 1 && k == at + 1) abort = 1'b0;
            if (ev == 2 && k == at) rst = 1'b1;
            if (rst && k == last) begin
                rst = 1'b0;
                req_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("idle_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_en", trunk_enable, 0);
        req_valid = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_sel", trunk_sel, 0);
        check("rst_mode", trunk_byte_mode, 0);
        check("rst_en", trunk_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        burst(1, 30, 2, 0, 0);
        burst(1, 31, 3, 0, 0);
        burst(0, 6, 4, 0, 0);
        burst(0, 13, 1, 0, 0);
        check("lane_mode", trunk_byte_mode, 0);
        burst(1, 5, 0, 0, 0);
        burst(1, 2, 5, 1, 5);
        burst(1, 9, 3, 2, 4);
        burst(0, 3, 2, 3, 0);
        burst(1, 7, 2, 1, 7);
        burst(1, 0, 1, 1, 1);
        for (int r = 0; r < 150; r++) begin
            int m = int'($urandom_range(0, 1));
            int st = int'($urandom_range(0, 31));
            int len = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 32));
            int full = len == 0 ? 1 : 2 + len * P + (len - 1) * G;
            int e = int'($urandom_range(0, 9));
            int ev = e < 6 ? 0 : e < 8 ? 1 : e == 8 ? 2 : 3;
            int at = ev == 1 ? int'($urandom_range(1, full)) : ev == 2 && full > 1 ? int'($urandom_range(1, full - 1)) : 0;
            if (ev == 2 && full < 2) ev = 0;
            burst(m[0], st, len, ev, at);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
